// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: turns a note frequency in Hz into a 50% duty square wave on
// the buzzer pin. The half-period comes from an iterative restoring divider, and
// a new half-period is only taken at a waveform edge so no runt pulses appear.
module buzzer_tone_gen #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned HZ_W     = 12,
    parameter int unsigned DIV_W    = 26,
    parameter int unsigned MIN_HALF = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [HZ_W-1:0] hz,
    output logic            buzzer,
    output logic            busy,
    output logic            tone_on
);

    localparam int unsigned CNT_W = $clog2(DIV_W + 1);
    localparam int unsigned REM_W = DIV_W + 1;

    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ / 2);
    localparam logic [DIV_W-1:0] MIN_Q    = DIV_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DIV_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [HZ_W-1:0]   last_hz_q;
    logic              redo_q;
    logic [REM_W-1:0]  rem_q;
    logic [DIV_W-1:0]  quo_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DIV_W-1:0]  pend_half_q;
    logic              pend_valid_q;
    logic [DIV_W-1:0]  active_half_q;
    logic [DIV_W-1:0]  phase_q;
    logic              buzzer_q;
    logic              busy_q;
    logic              tone_on_q;

    logic [REM_W:0]    rem_shift;
    logic [REM_W:0]    divisor_ext;
    logic              quo_bit;
    logic [REM_W-1:0]  rem_d;
    logic [DIV_W-1:0]  quo_d;
    logic [DIV_W-1:0]  clamped_half;
    logic              hz_change;
    logic              wrap;

    // One restoring-division step plus the change/wrap/clamp decodes.
    always_comb begin
        rem_shift    = {rem_q, quo_q[DIV_W-1]};
        divisor_ext  = (REM_W + 1)'(last_hz_q);
        quo_bit      = (rem_shift >= divisor_ext);
        rem_d        = quo_bit ? REM_W'(rem_shift - divisor_ext) : REM_W'(rem_shift);
        quo_d        = {quo_q[DIV_W-2:0], quo_bit};
        clamped_half = (quo_q < MIN_Q) ? MIN_Q : quo_q;
        hz_change    = (hz != last_hz_q);
        wrap         = (phase_q == (active_half_q - DIV_W'(1)));
    end

    // Tone generator and divider FSM; later assignments take priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            last_hz_q     <= '0;
            redo_q        <= 1'b0;
            rem_q         <= '0;
            quo_q         <= '0;
            bit_cnt_q     <= '0;
            pend_half_q   <= '0;
            pend_valid_q  <= 1'b0;
            active_half_q <= '0;
            phase_q       <= '0;
            buzzer_q      <= 1'b0;
            busy_q        <= 1'b0;
            tone_on_q     <= 1'b0;
        end else begin
            // Running tone: wrap toggles the pin and is the only place a new
            // half-period is adopted; from silence a pending value starts low.
            if (tone_on_q) begin
                if (wrap) begin
                    phase_q  <= '0;
                    buzzer_q <= ~buzzer_q;
                    if (pend_valid_q) begin
                        active_half_q <= pend_half_q;
                        pend_valid_q  <= 1'b0;
                    end
                end else begin
                    phase_q <= phase_q + DIV_W'(1);
                end
            end else if (pend_valid_q) begin
                active_half_q <= pend_half_q;
                phase_q       <= '0;
                buzzer_q      <= 1'b0;
                tone_on_q     <= 1'b1;
                pend_valid_q  <= 1'b0;
            end

            // Divider: a result landing in DONE overrides a same-cycle consume.
            unique case (state_q)
                S_IDLE: begin
                    if (hz_change || redo_q) begin
                        last_hz_q <= hz;
                        redo_q    <= 1'b0;
                        if (hz != '0) begin
                            state_q   <= S_DIV;
                            busy_q    <= 1'b1;
                            rem_q     <= '0;
                            quo_q     <= DIVIDEND;
                            bit_cnt_q <= '0;
                        end else begin
                            // Silence is immediate, not edge aligned.
                            buzzer_q      <= 1'b0;
                            tone_on_q     <= 1'b0;
                            phase_q       <= '0;
                            pend_valid_q  <= 1'b0;
                            active_half_q <= '0;
                        end
                    end
                end
                S_DIV: begin
                    rem_q     <= rem_d;
                    quo_q     <= quo_d;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    if (hz_change) begin
                        redo_q <= 1'b1;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    pend_half_q  <= clamped_half;
                    pend_valid_q <= 1'b1;
                    state_q      <= S_IDLE;
                    if (hz_change) begin
                        redo_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign buzzer  = buzzer_q;
    assign busy    = busy_q;
    assign tone_on = tone_on_q;

endmodule
